cmd_serializer: RTL and testbench
=================================

// Module: cmd_serializer
// PURPOSE
//  Downstream of the reset/command controller. Takes its 32-bit command stream over
//  valid/ready and shifts each word onto a single-wire serial link to the front-end.
//  Frame: start bit (0), 32 data bits MSB first, optional even-parity bit, IDLE_BITS stop bits (1).
//  The first word after reset is therefore always the controller's reset code.
// PARAMETERS
//  CLK_DIV    4   clk cycles per serial bit; legal range 2..255
//  IDLE_BITS  2   stop/idle bit periods after each frame; legal range 1..15
// PORTS
//  clk            in   1   system clock; single clock domain
//  rst_n          in   1   asynchronous, active-low reset
//  cmd_in_valid   in   1   command word valid
//  cmd_in_ready   out  1   block can accept a word; registered
//  cmd_in         in   32  command word
//  tx             out  1   serial line; idles high; registered
//  busy           out  1   high from acceptance until end of the last stop bit
//  frame_count    out  16  completed frames; wraps
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous, takes effect immediately):
//   - Outputs: tx=1, cmd_in_ready=0, busy=0, frame_count=0.
//   - State: IDLE; bit and divider counters cleared.
//  Exit from reset: cmd_in_ready=1 on the first clk edge after rst_n goes high.
//  States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  IDLE:
//   - tx=1, cmd_in_ready=1.
//   - The edge with cmd_in_valid & cmd_in_ready latches cmd_in into the shift register
//     and clears cmd_in_ready and sets busy on that same edge.
//   - State goes to START. Latency: tx=0 from the cycle after acceptance.
//  START: tx=0 for CLK_DIV cycles.
//  DATA:
//   - Bits 31..0 in order, each held for CLK_DIV cycles.
//   - A 5-bit counter tracks the bit index; it is 0 after bit 0 is sent.
//  PARITY (macro only): tx = ^word (even parity over the 32 bits) for CLK_DIV cycles.
//  STOP:
//   - tx=1 for IDLE_BITS*CLK_DIV cycles.
//   - On the final cycle edge: busy=0, cmd_in_ready=1, frame_count+=1, state=IDLE.
//  Frame length:
//   - N = 1+32+P+IDLE_BITS bits, where P=1 with the macro, else 0.
//   - Frame is N*CLK_DIV cycles.
//   - With cmd_in_valid held high, acceptance-to-acceptance is N*CLK_DIV+1 cycles;
//     tx=1 in the gap cycle.
//  Handshake:
//   - cmd_in is sampled only at acceptance; later changes have no effect on the frame.
//   - cmd_in_valid during a frame is ignored (ready=0). The upstream holds the word.
//  frame_count: 16-bit, 0xFFFF -> 0x0000 on wrap; no saturation.
//  Reset mid-frame: the partial frame is abandoned; tx returns high immediately; no count.
//  Divider counter: 8 bits. Stop counter: width ceil(log2(IDLE_BITS*CLK_DIV+1)).
// CONFIGURATION
//  CMD_SER_PARITY_EN defined:
//   - PARITY state present; one even-parity bit after bit 0.
//  CMD_SER_PARITY_EN undefined:
//   - PARITY state and its logic removed; DATA goes straight to STOP.
//   - Frame is one bit shorter.
// TESTING (CLK_DIV=4, IDLE_BITS=2)
//  1. Reset release: rst_n 0->1 -> tx=1 throughout; cmd_in_ready=1 at the 1st edge;
//     frame_count=0.
//  2. Send 0xF000_0000 (parity build) -> tx: 4 cyc 0, 16 cyc 1, 112 cyc 0, 4 cyc 0
//     (parity 0), 8 cyc 1. busy is 144 cycles; frame_count=1.
//  3. Send 0x0000_0001 (parity build) -> last data bit high for 4 cycles; parity bit 1;
//     no-parity build: frame is 140 cycles.
//  4. Hold cmd_in_valid with 3 words -> accepts spaced 145 cycles (141 no-parity);
//     words on tx in order; frame_count=3.
//  5. rst_n pulsed low mid-DATA (bit 12) -> tx=1 asynchronously; frame_count=0;
//     next word transmitted complete and uncorrupted.
//  6. Preload frame_count to 0xFFFF via 65535 frames or force -> next frame gives 0x0000.

Source files
------------

// File: rtl/cmd_serializer.sv
// cmd_serializer: accepts 32-bit command words over valid/ready and shifts each
// word onto a single-wire serial link.
// Frame: start bit (0), 32 data bits MSB first, optional even-parity bit,
// IDLE_BITS stop bits (1). Each bit lasts CLK_DIV clk cycles.
// Optional feature: define CMD_SER_PARITY_EN to append an even-parity bit.
//
// state  | meaning
// IDLE   | line high, ready for a new word
// START  | start bit (tx=0)
// DATA   | 32 data bits, MSB first
// PARITY | even parity over the word (CMD_SER_PARITY_EN only)
// STOP   | stop/idle bits (tx=1), frame completes on the last cycle
module cmd_serializer #(
  parameter int CLK_DIV   = 4,
  parameter int IDLE_BITS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_in_valid,
  output logic        cmd_in_ready,
  input  logic [31:0] cmd_in,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam int STOP_CYC = IDLE_BITS * CLK_DIV;
  localparam int STOP_W   = $clog2(STOP_CYC + 1);

  localparam logic [7:0]        DIV_LOAD  = 8'(CLK_DIV - 1);
  localparam logic [STOP_W-1:0] STOP_LOAD = STOP_W'(STOP_CYC - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef CMD_SER_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]        state;
  logic [31:0]       shreg;
  logic [7:0]        div_cnt;
  logic [4:0]        bit_cnt;
  logic [STOP_W-1:0] stop_cnt;
`ifdef CMD_SER_PARITY_EN
  logic              parity_bit;
`endif

  // Frame sequencer: tx is registered, so each transition loads the level
  // for the bit period that begins on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      shreg        <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      stop_cnt     <= '0;
      tx           <= 1'b1;
      busy         <= 1'b0;
      cmd_in_ready <= 1'b0;
      frame_count  <= '0;
`ifdef CMD_SER_PARITY_EN
      parity_bit   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (cmd_in_valid && cmd_in_ready) begin
            shreg        <= cmd_in;
`ifdef CMD_SER_PARITY_EN
            parity_bit   <= ^cmd_in;
`endif
            cmd_in_ready <= 1'b0;
            busy         <= 1'b1;
            tx           <= 1'b0;
            div_cnt      <= DIV_LOAD;
            state        <= S_START;
          end else begin
            cmd_in_ready <= 1'b1;
          end
        end
        S_START: begin
          if (div_cnt == 8'd0) begin
            tx      <= shreg[31];
            shreg   <= {shreg[30:0], 1'b0};
            bit_cnt <= 5'd31;
            div_cnt <= DIV_LOAD;
            state   <= S_DATA;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        S_DATA: begin
          if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else if (bit_cnt != 5'd0) begin
            tx      <= shreg[31];
            shreg   <= {shreg[30:0], 1'b0};
            bit_cnt <= bit_cnt - 5'd1;
            div_cnt <= DIV_LOAD;
          end else begin
`ifdef CMD_SER_PARITY_EN
            tx       <= parity_bit;
            div_cnt  <= DIV_LOAD;
            state    <= S_PARITY;
`else
            tx       <= 1'b1;
            stop_cnt <= STOP_LOAD;
            state    <= S_STOP;
`endif
          end
        end
`ifdef CMD_SER_PARITY_EN
        S_PARITY: begin
          if (div_cnt == 8'd0) begin
            tx       <= 1'b1;
            stop_cnt <= STOP_LOAD;
            state    <= S_STOP;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
`endif
        S_STOP: begin
          tx <= 1'b1;
          if (stop_cnt == '0) begin
            busy         <= 1'b0;
            cmd_in_ready <= 1'b1;
            frame_count  <= frame_count + 16'd1;
            state        <= S_IDLE;
          end else begin
            stop_cnt <= stop_cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_serializer.sv
// Testbench for cmd_serializer: directed and random words compared cycle by
// cycle against a frame model built from the link format.
module tb_cmd_serializer;

  localparam int D  = 4;
  localparam int IB = 2;
`ifdef CMD_SER_PARITY_EN
  localparam int P  = 1;
`else
  localparam int P  = 0;
`endif
  localparam int N  = 1 + 32 + P + IB;
  localparam int F  = N * D;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_in_valid;
  logic        cmd_in_ready;
  logic [31:0] cmd_in;
  logic        tx;
  logic        busy;
  logic [15:0] frame_count;

  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] exp_count;
  logic [31:0] b0, b1, b2;

  cmd_serializer #(.CLK_DIV(D), .IDLE_BITS(IB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_in_valid (cmd_in_valid),
    .cmd_in_ready (cmd_in_ready),
    .cmd_in       (cmd_in),
    .tx           (tx),
    .busy         (busy),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Level of bit slot i of the frame carrying word w.
  function automatic logic exp_bit(input logic [31:0] w, input int i);
    if (i == 0)                  return 1'b0;
    if (i <= 32)                 return w[32 - i];
    if (P == 1 && i == 33)       return ^w;
    return 1'b1;
  endfunction

  // Called #1 after the acceptance edge; checks the whole frame and its end.
  task automatic run_frame(input logic [31:0] w, input logic keep, input logic [31:0] nxt);
    cmd_in_valid = keep;
    cmd_in       = keep ? nxt : $urandom;
    chk("ready_after_accept", {31'd0, cmd_in_ready}, 32'd0);
    for (int k = 0; k < F; k++) begin
      chk($sformatf("tx[%0d]", k), {31'd0, tx}, {31'd0, exp_bit(w, k / D)});
      chk($sformatf("busy[%0d]", k), {31'd0, busy}, 32'd1);
      if (k == F / 2 && !keep) cmd_in = ~w;
      @(posedge clk); #1;
    end
    exp_count = exp_count + 16'd1;
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("ready_end", {31'd0, cmd_in_ready}, 32'd1);
    chk("tx_gap", {31'd0, tx}, 32'd1);
    chk("frame_count", {16'd0, frame_count}, {16'd0, exp_count});
  endtask

  task automatic wait_ready();
    int n = 0;
    while (cmd_in_ready !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_timeout", {31'd0, cmd_in_ready}, 32'd1);
  endtask

  task automatic send(input logic [31:0] w);
    wait_ready();
    cmd_in_valid = 1'b1;
    cmd_in       = w;
    @(posedge clk); #1;
    run_frame(w, 1'b0, 32'd0);
  endtask

  // Directed sequence: reset, known words, random words, back-to-back,
  // mid-frame reset, counter wrap.
  initial begin
    rst_n        = 1'b0;
    cmd_in_valid = 1'b0;
    cmd_in       = '0;
    exp_count    = '0;
    #23;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_ready", {31'd0, cmd_in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {16'd0, frame_count}, 32'd0);

    @(negedge clk) rst_n = 1'b1;
    chk("rel_tx", {31'd0, tx}, 32'd1);
    @(posedge clk); #1;
    chk("rel_ready", {31'd0, cmd_in_ready}, 32'd1);
    chk("rel_tx1", {31'd0, tx}, 32'd1);
    chk("rel_count", {16'd0, frame_count}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_tx", {31'd0, tx}, 32'd1);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end

    send(32'hF000_0000);
    send(32'h0000_0001);
    repeat (4) send($urandom);

    b0 = $urandom; b1 = $urandom; b2 = $urandom;
    wait_ready();
    cmd_in_valid = 1'b1;
    cmd_in       = b0;
    @(posedge clk); #1;
    run_frame(b0, 1'b1, b1);
    @(posedge clk); #1;
    run_frame(b1, 1'b1, b2);
    @(posedge clk); #1;
    run_frame(b2, 1'b0, 32'd0);

    wait_ready();
    cmd_in_valid = 1'b1;
    cmd_in       = $urandom;
    @(posedge clk); #1;
    cmd_in_valid = 1'b0;
    repeat ((1 + 19) * D + 2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, cmd_in_ready}, 32'd0);
    chk("midrst_count", {16'd0, frame_count}, 32'd0);
    exp_count = '0;
    @(negedge clk) rst_n = 1'b1;
    send($urandom);

    wait_ready();
    force dut.frame_count = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frame_count;
    #1;
    chk("preload", {16'd0, frame_count}, 32'h0000_FFFF);
    exp_count = 16'hFFFF;
    send($urandom);
    send($urandom);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
